iram_ctrl: RTL and testbench
============================

IRAM_CTRL -- requirements
Module: iram_ctrl

Interface
REQ-001 Parameter PC_SIZE, default 32: width in bits of byte addresses.
REQ-002 Parameter WORD_SIZE, default 32: width in bits of one memory word; one word is 4 bytes.
REQ-003 Parameter LINE_WORDS, default 4: words per cache line; SHALL be a power of two, 2 or greater.
REQ-004 clk  in  1  the single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 miss_cache  in  1  fetch unit reports an instruction cache miss.
REQ-007 ram_address  in  PC_SIZE  byte address of the missed instruction.
REQ-008 mem_word  out  WORD_SIZE  word delivered to the fetch unit.
REQ-009 word_ready  out  1  one-cycle pulse: mem_word and word_addr are valid.
REQ-010 word_addr  out  PC_SIZE  byte address of the word currently on mem_word.
REQ-011 line_done  out  1  one-cycle pulse: the last word of the line is delivered.
REQ-012 busy  out  1  high while a line refill is in progress.
REQ-013 ram_req  out  1  level request to the RAM; held high until the RAM returns ram_valid.
REQ-014 ram_addr  out  PC_SIZE  word-aligned byte address requested from the RAM.
REQ-015 ram_rdata  in  WORD_SIZE  read data from the RAM.
REQ-016 ram_valid  in  1  ram_rdata is valid and completes the current request; RAM latency is 1 cycle or more, unbounded.

Function
REQ-017 The FSM SHALL have three states: IDLE, FETCH and DONE.
REQ-018 In IDLE, miss_cache=1 at edge N SHALL latch ram_address, enter FETCH, and raise busy and ram_req from N+1.
REQ-019 The first ram_addr SHALL be the critical word: the latched address with bits [1:0] forced to 0.
REQ-020 Line base = latched address with its low log2(LINE_WORDS)+2 bits cleared; the word index SHALL count modulo LINE_WORDS, so addresses wrap to the line base after the last word (critical-word-first).
REQ-021 In FETCH, ram_valid=1 at edge M SHALL register mem_word=ram_rdata, word_addr=current ram_addr and word_ready=1 for cycle M+1 only.
REQ-022 On that same edge M the index SHALL advance, and ram_addr SHALL show the next address from M+1; ram_req SHALL stay high with no gap between words.
REQ-023 A word counter SHALL count delivered words. On the LINE_WORDS-th ram_valid, the FSM SHALL go to DONE, drop ram_req from M+1, and pulse line_done in cycle M+1, coincident with the final word_ready.
REQ-024 DONE SHALL last exactly one cycle with busy=0, then go to IDLE; miss_cache in DONE SHALL be ignored.
REQ-025 ram_addr SHALL hold stable while ram_req=1 and ram_valid=0.
REQ-026 ram_valid SHALL be ignored while ram_req=0 (IDLE or DONE): no output change.
REQ-027 miss_cache and ram_address SHALL be ignored while busy=1; a refill always completes once started, even if miss_cache drops.
REQ-028 Back-to-back refills: the earliest next ram_req rises 2 cycles after line_done (DONE, then IDLE sampling).
REQ-029 mem_word and word_addr SHALL hold their last value while word_ready=0.

Reset
REQ-030 rst=1 at any edge SHALL force state IDLE, ram_req=0, busy=0, word_ready=0, line_done=0, mem_word=0, word_addr=0, ram_addr=0, and clear the index and counter.
REQ-031 rst during FETCH SHALL abort the refill: no further word_ready, and ram_valid arriving afterward is ignored.
REQ-032 rst has priority over miss_cache and ram_valid asserted on the same edge.

Verification
REQ-033 Aligned miss, ram_address=0x100, RAM latency 1 -> ram_addr 0x100, 0x104, 0x108, 0x10C; word_ready in 4 consecutive cycles; line_done with the 0x10C word; busy=0 in the next cycle.
REQ-034 Wrap, ram_address=0x20A, latency 3 -> ram_addr order 0x208, 0x20C, 0x200, 0x204; ram_req continuously high; 4 word_ready pulses each 3 cycles apart.
REQ-035 miss_cache held high, plus a new ram_address=0x400 mid-refill -> first line completes unchanged; second refill ram_req rises 2 cycles after line_done with ram_addr=0x400.
REQ-036 Stray ram_valid=1 with data 0xDEADBEEF in IDLE -> word_ready stays 0 and mem_word keeps its value.
REQ-037 rst after the 2nd word of a refill -> all outputs reach reset values next cycle; later ram_valid produces no word_ready; a new miss to 0x300 then refills normally.
REQ-038 Random RAM latency 1-8 over 100 misses -> scoreboard checks every word_addr/mem_word pair against the memory model, and exactly LINE_WORDS word_ready pulses per line_done.

Source files
------------

// File: rtl/iram_ctrl.sv
// Instruction RAM refill controller: fetches one cache line, critical word first.
// Ports: clk/rst, miss_cache/ram_address in; mem_word/word_ready/word_addr/line_done/busy/ram_req/ram_addr out; ram_rdata/ram_valid in.
module iram_ctrl #(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_cache,
  input  logic [PC_SIZE-1:0]   ram_address,
  output logic [WORD_SIZE-1:0] mem_word,
  output logic                 word_ready,
  output logic [PC_SIZE-1:0]   word_addr,
  output logic                 line_done,
  output logic                 busy,
  output logic                 ram_req,
  output logic [PC_SIZE-1:0]   ram_addr,
  input  logic [WORD_SIZE-1:0] ram_rdata,
  input  logic                 ram_valid
);

  localparam int IW = $clog2(LINE_WORDS);
  localparam int LB = IW + 2;
  localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]            r_state;
  logic [PC_SIZE-LB-1:0] r_tag;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_cnt;
  logic [WORD_SIZE-1:0]  r_mem_word;
  logic [PC_SIZE-1:0]    r_word_addr;
  logic                  r_word_ready;
  logic                  r_line_done;
  logic [PC_SIZE-1:0]    w_addr;
  logic                  w_fetch;

  // Index wraps naturally inside the line, giving critical-word-first order.
  assign w_addr  = {r_tag, r_idx, 2'b00};
  assign w_fetch = (r_state == S_FETCH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tag        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_mem_word   <= '0;
      r_word_addr  <= '0;
      r_word_ready <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_word_ready <= 1'b0;
      r_line_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_cache) begin
            r_tag   <= ram_address[PC_SIZE-1:LB];
            r_idx   <= ram_address[LB-1:2];
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (ram_valid) begin
            r_mem_word   <= ram_rdata;
            r_word_addr  <= w_addr;
            r_word_ready <= 1'b1;
            r_idx        <= r_idx + 1'b1;
            if (r_cnt == LAST) begin
              r_cnt       <= '0;
              r_line_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_word   = r_mem_word;
  assign word_ready = r_word_ready;
  assign word_addr  = r_word_addr;
  assign line_done  = r_line_done;
  assign busy       = w_fetch;
  assign ram_req    = w_fetch;
  assign ram_addr   = w_addr;

endmodule

// File: tb/tb_iram_ctrl.sv
// Self-checking bench for iram_ctrl: vector table plus multi-cycle refill sequences.
// Drives inputs and samples outputs 1 ns after each rising edge.
module tb_iram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_cache;
  logic [31:0] ram_address;
  logic [31:0] mem_word;
  logic        word_ready;
  logic [31:0] word_addr;
  logic        line_done;
  logic        busy;
  logic        ram_req;
  logic [31:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_valid;

  int n_chk = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  iram_ctrl #(.PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .miss_cache(miss_cache),
    .ram_address(ram_address), .mem_word(mem_word),
    .word_ready(word_ready), .word_addr(word_addr),
    .line_done(line_done), .busy(busy), .ram_req(ram_req),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata), .ram_valid(ram_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent count of word pulses per completed line.
  always @(negedge clk) begin
    if (rst) wr_cnt = 0;
    else begin
      if (word_ready) wr_cnt++;
      if (line_done) begin
        chk("words_per_line", wr_cnt, 4);
        wr_cnt = 0;
      end
    end
  end

  typedef struct {
    logic        miss;
    logic [31:0] addr;
    logic        rv;
    logic [31:0] rdata;
    logic        e_wr;
    logic        e_ld;
    logic        e_busy;
    logic [31:0] e_ra;
    logic        ck_ra;
    logic [31:0] e_mw;
    logic [31:0] e_wa;
  } vec_t;

  vec_t vt[7];

  // Refill of the line containing a, critical word first.
  // lat=0 selects a random RAM latency 1..8 per word.
  task automatic refill(input logic [31:0] a, input int lat,
                        input logic hold_miss);
    logic [31:0] base;
    logic [31:0] exp;
    int l;
    base = {a[31:4], 4'h0};
    miss_cache  = 1'b1;
    ram_address = a;
    tick();
    miss_cache = hold_miss;
    chk("refill_req", ram_req, 1);
    chk("refill_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      exp = base | ((a + 32'(4 * k)) & 32'hC);
      l = (lat == 0) ? $urandom_range(8, 1) : lat;
      for (int w = 1; w < l; w++) begin
        chk("wait_ra", ram_addr, exp);
        tick();
        chk("wait_req", ram_req, 1);
        chk("wait_wr", word_ready, 0);
      end
      chk("ra", ram_addr, exp);
      ram_valid = 1'b1;
      ram_rdata = mem(ram_addr);
      tick();
      ram_valid = 1'b0;
      ram_rdata = 32'h0;
      chk("wr", word_ready, 1);
      chk("wa", word_addr, exp);
      chk("mw", mem_word, mem(exp));
      chk("ld", line_done, (k == 3) ? 32'd1 : 32'd0);
      chk("req_after", ram_req, (k == 3) ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    miss_cache = 1'b0;
    ram_address = '0;
    ram_rdata = '0;
    ram_valid = 1'b0;
    tick();
    tick();
    chk("rst_req", ram_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr", word_ready, 0);
    chk("rst_ld", line_done, 0);
    chk("rst_mw", mem_word, 0);
    chk("rst_wa", word_addr, 0);
    chk("rst_ra", ram_addr, 0);
    rst = 1'b0;
    tick();

    // Aligned miss at 0x100, latency 1, then strays in DONE and IDLE.
    vt[0] = '{1, 32'h100, 0, 0, 0, 0, 1, 32'h100, 1, 0, 0};
    vt[1] = '{0, 0, 1, 32'hA0, 1, 0, 1, 32'h104, 1, 32'hA0, 32'h100};
    vt[2] = '{0, 0, 1, 32'hA1, 1, 0, 1, 32'h108, 1, 32'hA1, 32'h104};
    vt[3] = '{0, 0, 1, 32'hA2, 1, 0, 1, 32'h10C, 1, 32'hA2, 32'h108};
    vt[4] = '{0, 0, 1, 32'hA3, 1, 1, 0, 0, 0, 32'hA3, 32'h10C};
    vt[5] = '{1, 32'h500, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0,
              32'hA3, 32'h10C};
    vt[6] = '{0, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'hA3, 32'h10C};
    for (int i = 0; i < 7; i++) begin
      miss_cache  = vt[i].miss;
      ram_address = vt[i].addr;
      ram_valid   = vt[i].rv;
      ram_rdata   = vt[i].rdata;
      tick();
      chk($sformatf("v%0d_wr", i), word_ready, vt[i].e_wr);
      chk($sformatf("v%0d_ld", i), line_done, vt[i].e_ld);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_req", i), ram_req, vt[i].e_busy);
      if (vt[i].ck_ra) chk($sformatf("v%0d_ra", i), ram_addr, vt[i].e_ra);
      chk($sformatf("v%0d_mw", i), mem_word, vt[i].e_mw);
      chk($sformatf("v%0d_wa", i), word_addr, vt[i].e_wa);
    end
    miss_cache = 1'b0;
    ram_valid = 1'b0;
    tick();
    chk("idle_after_vec", busy, 0);

    // Wrapping miss, latency 3.
    refill(32'h20A, 3, 1'b0);
    tick();
    chk("wrap_idle_busy", busy, 0);
    tick();

    // Miss held high with address changed mid-refill.
    miss_cache  = 1'b1;
    ram_address = 32'h600;
    tick();
    chk("b2b_req", ram_req, 1);
    for (int k = 0; k < 4; k++) begin
      chk("b2b_ra", ram_addr, 32'h600 + 32'(4 * k));
      ram_valid = 1'b1;
      ram_rdata = mem(ram_addr);
      tick();
      ram_address = 32'h400;
      chk("b2b_wa", word_addr, 32'h600 + 32'(4 * k));
      chk("b2b_mw", mem_word, mem(32'h600 + 32'(4 * k)));
    end
    ram_valid = 1'b0;
    chk("b2b_ld", line_done, 1);
    tick();
    chk("b2b_gap_req", ram_req, 0);
    tick();
    chk("b2b_next_req", ram_req, 1);
    chk("b2b_next_ra", ram_addr, 32'h400);
    miss_cache = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ram_valid = 1'b1;
      ram_rdata = mem(ram_addr);
      tick();
      chk("b2b2_wa", word_addr, 32'h400 + 32'(4 * k));
    end
    ram_valid = 1'b0;
    chk("b2b2_ld", line_done, 1);
    tick();
    tick();

    // Reset after the second word, with ram_valid on the reset edge.
    miss_cache  = 1'b1;
    ram_address = 32'h700;
    tick();
    miss_cache = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ram_valid = 1'b1;
      ram_rdata = mem(ram_addr);
      tick();
    end
    chk("pre_rst_wa", word_addr, 32'h704);
    rst = 1'b1;
    miss_cache = 1'b1;
    ram_address = 32'h900;
    tick();
    rst = 1'b0;
    miss_cache = 1'b0;
    chk("abort_req", ram_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wr", word_ready, 0);
    chk("abort_ld", line_done, 0);
    chk("abort_mw", mem_word, 0);
    chk("abort_wa", word_addr, 0);
    chk("abort_ra", ram_addr, 0);
    ram_rdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_stray_wr", word_ready, 0);
      chk("abort_stray_mw", mem_word, 0);
    end
    ram_valid = 1'b0;
    refill(32'h300, 2, 1'b0);
    tick();
    tick();

    // Random latency scoreboard over 100 misses.
    for (int m = 0; m < 100; m++) begin
      refill({16'h0, 14'($urandom()), 2'($urandom())}, 0, 1'b0);
      tick();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
